// File: rtl/toll_gate_ctrl_pkg.sv
// Shared types and codes for the hipass toll gate lane controller.
// Imported by the interface, the controller and its sub-modules.
package toll_gate_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TAG,
    OPEN,
    CLOSING,
    ALARM
  } state_t;

  localparam logic [1:0] EN_IDLE = 2'b00;
  localparam logic [1:0] EN_WAIT = 2'b10;
  localparam logic [1:0] EN_BUSY = 2'b01;

  localparam logic [3:0] HIPASS_OK = 4'b1111;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/toll_gate_if.sv
// Lane bus: sensors and tag code in, counter enable, barrier,
// alarm and tallies out.
interface toll_gate_if #(
  parameter int CNT_W = 8
);

  logic             car_arrive;
  logic             car_pass;
  logic [3:0]       hipass_in;
  logic [1:0]       en;
  logic             gate_open;
  logic             gate_closing;
  logic             alarm;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] viol_cnt;

  modport master (
    input  car_arrive,
    input  car_pass,
    input  hipass_in,
    output en,
    output gate_open,
    output gate_closing,
    output alarm,
    output pass_cnt,
    output viol_cnt
  );

  modport slave (
    output car_arrive,
    output car_pass,
    output hipass_in,
    input  en,
    input  gate_open,
    input  gate_closing,
    input  alarm,
    input  pass_cnt,
    input  viol_cnt
  );

endinterface

// File: rtl/toll_gate_ctrl_sat_counter.sv
// Saturating up-counter for the lane tallies.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/toll_gate_ctrl.sv
// Hipass lane controller: tag wait, barrier open/hold/close,
// violation alarm and saturating pass/violation tallies.
module toll_gate_ctrl
  import toll_gate_ctrl_pkg::*;
#(
  parameter int WAIT_CYC  = 32,
  parameter int HOLD_CYC  = 8,
  parameter int CLOSE_CYC = 4,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic rst,
  toll_gate_if.master bus
);

  localparam int MAX_CYC = max3(WAIT_CYC, HOLD_CYC, CLOSE_CYC);
  localparam int TMR_W   = $clog2(MAX_CYC);

  localparam logic [TMR_W-1:0] ONE        = TMR_W'(1);
  localparam logic [TMR_W-1:0] WAIT_LAST  = TMR_W'(WAIT_CYC - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] CLOSE_LAST = TMR_W'(CLOSE_CYC - 1);

  state_t           state;
  state_t           state_nxt;
  logic [TMR_W-1:0] tmr;
  logic             pass_lat;
  logic             tag_ok;
  logic             inc_pass;
  logic             inc_viol;

  logic [1:0]       en_d;
  logic             open_d;
  logic             closing_d;
  logic             alarm_d;

  assign tag_ok = (bus.hipass_in == HIPASS_OK);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= IDLE;
      bus.en           <= EN_IDLE;
      bus.gate_open    <= 1'b0;
      bus.gate_closing <= 1'b0;
      bus.alarm        <= 1'b0;
    end else begin
      state            <= state_nxt;
      bus.en           <= en_d;
      bus.gate_open    <= open_d;
      bus.gate_closing <= closing_d;
      bus.alarm        <= alarm_d;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.car_arrive) state_nxt = WAIT_TAG;
      end
      WAIT_TAG: begin
        if (tag_ok)               state_nxt = OPEN;
        else if (!bus.car_arrive) state_nxt = IDLE;
        else if (tmr == WAIT_LAST) state_nxt = ALARM;
      end
      OPEN: begin
        if (pass_lat && !bus.car_pass && tmr >= HOLD_LAST)
          state_nxt = CLOSING;
      end
      CLOSING: begin
        if (bus.car_pass)           state_nxt = OPEN;
        else if (tmr == CLOSE_LAST) state_nxt = IDLE;
      end
      ALARM: begin
        if (!bus.car_arrive && tmr == ONE) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the state being entered, then registered
  always_comb begin
    en_d      = EN_IDLE;
    open_d    = 1'b0;
    closing_d = 1'b0;
    alarm_d   = 1'b0;
    unique case (state_nxt)
      IDLE:     en_d = EN_IDLE;
      WAIT_TAG: en_d = EN_WAIT;
      OPEN: begin
        en_d   = EN_BUSY;
        open_d = 1'b1;
      end
      CLOSING: begin
        en_d      = EN_BUSY;
        closing_d = 1'b1;
      end
      ALARM: begin
        en_d    = EN_BUSY;
        alarm_d = 1'b1;
      end
      default: en_d = EN_IDLE;
    endcase
  end

  // Shared timer restarts on every state change; in ALARM it
  // counts consecutive car_arrive-low cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tmr      <= '0;
      pass_lat <= 1'b0;
    end else begin
      if (state_nxt != state) begin
        tmr <= '0;
      end else begin
        unique case (state)
          WAIT_TAG, CLOSING: tmr <= tmr + ONE;
          OPEN: if (tmr < HOLD_LAST) tmr <= tmr + ONE;
          ALARM: tmr <= bus.car_arrive ? '0 : ONE;
          default: tmr <= '0;
        endcase
      end
      pass_lat <= ((state == OPEN) && pass_lat) ||
                  (((state == OPEN) || (state == CLOSING)) && bus.car_pass);
    end
  end

  assign inc_pass = (state == WAIT_TAG) && (state_nxt == OPEN);
  assign inc_viol = (state == WAIT_TAG) && (state_nxt == ALARM);

  sat_counter #(.W(CNT_W)) u_pass_cnt (
    .clk (clk),
    .rst (rst),
    .inc (inc_pass),
    .q   (bus.pass_cnt)
  );

  sat_counter #(.W(CNT_W)) u_viol_cnt (
    .clk (clk),
    .rst (rst),
    .inc (inc_viol),
    .q   (bus.viol_cnt)
  );

endmodule

// File: doc/toll_gate_ctrl.md
Name: toll_gate_ctrl

Overview:
Lane controller for the hipass toll gate. It detects an arriving car and drives the 2-bit enable into the hipass wait counter. It consumes the counter's delayed hipass_in code, then sequences the barrier through open, hold and close, raising an alarm when no valid tag arrives in time. It also keeps saturating pass and violation tallies for the lane display.

Parameters:
WAIT_CYC, 32, max cycles spent in WAIT_TAG before a violation is declared (>=2)
HOLD_CYC, 8, minimum cycles the barrier stays open (>=1)
CLOSE_CYC, 4, barrier motor close time in cycles (>=1)
CNT_W, 8, width of pass/violation tallies

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-low
car_arrive  in  1  entry loop sensor, 1 = car present before barrier
car_pass  in  1  exit loop sensor, 1 = car under/after barrier
hipass_in  in  4  tag code from the counter stage; 4'b1111 = valid tag, any other value = no tag
en  out  2  counter enable: 2'b00 idle, 2'b10 wait for tag, 2'b01 busy (the counter clears on any value other than 2'b10)
gate_open  out  1  barrier open command
gate_closing  out  1  barrier motor closing
alarm  out  1  violation lamp/buzzer
pass_cnt  out  CNT_W  valid-tag passages, saturating
viol_cnt  out  CNT_W  violations, saturating

Behaviour:
- Moore FSM. All outputs are registered and decoded from the current state only. Every transition takes effect on the clock edge after the sampled condition.
- Reset (rst==0 at a posedge), including mid-operation: state=IDLE; en=00; gate_open=0; gate_closing=0; alarm=0; pass_cnt=0; viol_cnt=0; all timers and latches cleared.
- IDLE (en=00): car_arrive==1 -> WAIT_TAG, wait timer=0.
- WAIT_TAG (en=10): each cycle the wait timer increments.
  - hipass_in==4'b1111 -> OPEN, pass_cnt+1.
  - Else, when the timer reaches WAIT_CYC-1 -> ALARM, viol_cnt+1.
  - If a valid tag and the timeout coincide, the tag wins.
  - car_arrive dropping to 0 (car reversed) -> IDLE, with no tally change.
- OPEN (en=01, gate_open=1): the hold timer counts from 0. A pass latch sets when car_pass==1. Exit to CLOSING when the pass latch is set, car_pass==0 and the hold timer >= HOLD_CYC-1.
- CLOSING (en=01, gate_closing=1, gate_open=0): lasts CLOSE_CYC cycles, then -> IDLE.
  - Safety: car_pass==1 during CLOSING -> OPEN, hold timer reset, pass latch set. This overrides the close completion in the same cycle.
- ALARM (en=01, alarm=1, gate closed): late hipass_in values are ignored. Exit -> IDLE once car_arrive==0 for 2 consecutive cycles.
- Tallies saturate at 2^CNT_W-1 and never wrap.
- Timers are sized as clog2 of the largest parameter.
- hipass_in is sampled only in WAIT_TAG. Values other than 1111 or 0000 are treated as no tag.
- Latency: car_arrive sampled at edge t gives en=10 at t+1. A valid tag sampled at edge k gives gate_open=1 and the incremented pass_cnt at k+1. With no tag, alarm=1 WAIT_CYC cycles after en first goes to 10.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, WAIT_TAG, OPEN, CLOSING, ALARM);
  - the en codes EN_IDLE=2'b00, EN_WAIT=2'b10, EN_BUSY=2'b01;
  - HIPASS_OK=4'b1111.
- One sub-module, sat_counter (parameter width W; inputs clk, rst, inc; output q), instantiated twice for pass_cnt and viol_cnt. It follows the same synchronous active-low reset.

Test Plan:
1. Reset then car_arrive=1 at cycle 0; hipass_in=1111 at cycle 10 -> en=10 during cycles 1-10; gate_open=1 from cycle 11; pass_cnt=1; en=01.
2. Tag path continued: car_pass pulses at cycles 13-14 -> gate_open holds until the hold timer reaches 7 (cycle 18); gate_closing=1 for 4 cycles; then IDLE with en=00.
3. car_arrive held high, hipass_in=0000 throughout -> alarm=1 exactly 32 cycles after en went to 10; viol_cnt=1. car_arrive low for 2 cycles -> IDLE, alarm=0.
4. During CLOSING cycle 2, car_pass=1 -> gate_open=1 on the next cycle and gate_closing=0. The close sequence restarts only after the hold time is met and car_pass==0.
5. Tag arrives on the same cycle as the timeout -> OPEN; pass_cnt increments; viol_cnt unchanged. Also apply hipass_in=0101 -> treated as no tag.
6. Drive 300 tagged passages -> pass_cnt stays at 255. Assert rst=0 during OPEN -> gate_open=0, all counts 0 on the next cycle.
